inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
RV32I instruction encoder, the inverse of the ID-stage decoder. It accepts a decoded request through a valid/ready handshake: an opcode_t class, register indices, fun3, fun7 (instruction bit 30) and a full 32-bit immediate. It legality-checks the request, packs it into a 32-bit instruction word and buffers the result in a small FIFO for a valid/ready consumer. Used by the debug/self-test instruction injector ahead of IF and as a golden-model stimulus source in pipeline benches.

Parameters:
DEPTH, 2, output FIFO entries; power of two, minimum 2
ECNT_W, 16, width of saturating illegal-request counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_opcode  input  opcode_t (5)  target class, equals instruction[6:2]
in_rd  input  5  destination register
in_rs1  input  5  source 1
in_rs2  input  5  source 2
in_fun3  input  3  instruction[14:12]
in_fun7  input  1  instruction[30]
in_imm  input  32  byte-accurate immediate value (sign-extended where applicable)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer pop
out_inst  output  32  encoded instruction at FIFO head
err_illegal  output  1  one-cycle pulse: an accepted request was illegal and dropped
err_count  output  ECNT_W  saturating count of illegal requests

Behaviour:
- Reset (synchronous, also mid-operation): FIFO flushed; out_valid=0; out_inst=32'h00000013 (ADDI x0,x0,0); err_illegal=0; err_count=0; in_ready=1 in the cycle after reset deasserts. Pending requests are discarded.
- Handshake: in_ready = !full. There is no full-bypass: a simultaneous pop while full does not raise in_ready in the same cycle.
- Output: out_valid = !empty and out_inst = head entry; pop on out_valid && out_ready. When empty, out_inst=32'h00000013.
- Latency: an accepted legal request appears at out_inst on the next clk edge if the FIFO was empty. Push and pop in the same cycle are both performed, and count is unchanged. Order is strictly FIFO. Read/write pointers wrap modulo DEPTH.
- Packing: inst[6:0]={in_opcode,2'b11}.
  - R: fun7 field={1'b0,in_fun7,5'b0}.
  - I-arith: shifts (fun3 1/5) use imm[4:0] plus bit30=in_fun7. Others use imm[11:0].
  - LOAD/JALR: imm[11:0].
  - S: imm[11:5] / imm[4:0].
  - SB: imm[12|10:5] / imm[4:1|11].
  - UJ: imm[20|10:1|11|19:12].
  - LUI/AUIPC: imm[31:12].
  - Unused fields are zero; rd is zero for S/SB.
- Illegal (request accepted, not pushed, err_illegal pulses the next cycle):
  - opcode not in {R, IMM, LOAD, JALR, S, SB, UJ, LUI, AUIPC}.
  - R with fun7=1 and fun3 not in {0,5}.
  - IMM with fun7=1 and fun3!=5.
  - IMM shift with imm[31:5]!=0.
  - I/S imm not a 12-bit signed value.
  - LOAD fun3 in {3,6,7}.
  - S fun3>2.
  - JALR fun3!=0.
  - SB fun3 in {2,3}, imm odd, or imm outside 13-bit signed range.
  - UJ imm odd or outside 21-bit signed range.
  - U imm[11:0]!=0.
- err_count increments per illegal request and saturates at all-ones. An illegal request never occupies FIFO space. An illegal request arriving while full is not accepted, since in_ready=0.

Test Plan:
- Reset, then R ADD rd=3 rs1=1 rs2=2 -> out_inst=0x002081B3 one cycle later. SUB rd=5 rs1=6 rs2=7 fun7=1 -> 0x407302B3.
- IMM ADDI rd=1 rs1=0 imm=5 -> 0x00500093. LUI rd=1 imm=0x12345000 -> 0x123450B7. S SW rs1=1 rs2=2 fun3=2 imm=4 -> 0x0020A223. SB BEQ rs1=1 rs2=2 imm=8 -> 0x00208463.
- Hold out_ready=0 and push 3 legal requests with DEPTH=2 -> in_ready=0 after 2 pushes. Release out_ready -> outputs emerge in order and in_ready returns the cycle after the first pop.
- Illegal cases: SB imm=7; LOAD fun3=3; IMM SLLI imm=32; UJ imm=0x100000 -> each accepted, no push, err_illegal one-cycle pulse, err_count ends at 4.
- Continuous push/pop with out_ready=1 for 10 requests -> one instruction per cycle, no bubbles, pointers wrap cleanly.
- Assert rst with 2 entries queued -> next cycle out_valid=0, out_inst=0x00000013, err_count=0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: legality-checks a decoded request,
// packs it into an instruction word and queues it in a small FIFO.
package inst_encoder_pkg;
  typedef enum logic [4:0] {
    OP_LOAD  = 5'b00000,
    OP_IMM   = 5'b00100,
    OP_AUIPC = 5'b00101,
    OP_S     = 5'b01000,
    OP_R     = 5'b01100,
    OP_LUI   = 5'b01101,
    OP_SB    = 5'b11000,
    OP_JALR  = 5'b11001,
    OP_UJ    = 5'b11011
  } opcode_t;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ECNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  opcode_t           in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_fun3,
  input  logic              in_fun7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic              err_illegal,
  output logic [ECNT_W-1:0] err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;

  logic [6:0]  op7;
  logic [31:0] word;
  logic        illegal;
  logic        is_shift;
  logic        fits12, fits13, fits21;
  logic        full, empty;
  logic        accept, push, pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_inst    = empty ? NOP : mem_q[rd_q];
  assign err_illegal = err_q;
  assign err_count   = ecnt_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && !illegal;
  assign pop    = out_valid && out_ready;

  // Range checks: upper bits must all equal the sign bit.
  always_comb begin
    op7      = {in_opcode, 2'b11};
    is_shift = (in_fun3 == 3'd1) || (in_fun3 == 3'd5);
    fits12   = (&in_imm[31:11]) || !(|in_imm[31:11]);
    fits13   = (&in_imm[31:12]) || !(|in_imm[31:12]);
    fits21   = (&in_imm[31:20]) || !(|in_imm[31:20]);
  end

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      in_opcode == OP_R: begin
        word = {1'b0, in_fun7, 5'b0, in_rs2,
                in_rs1, in_fun3, in_rd, op7};
        illegal = in_fun7 && (in_fun3 != 3'd0)
                          && (in_fun3 != 3'd5);
      end
      in_opcode == OP_IMM: begin
        if (is_shift) begin
          word = {1'b0, in_fun7, 5'b0, in_imm[4:0],
                  in_rs1, in_fun3, in_rd, op7};
          illegal = |in_imm[31:5];
        end else begin
          word = {in_imm[11:0], in_rs1,
                  in_fun3, in_rd, op7};
          illegal = !fits12;
        end
        if (in_fun7 && (in_fun3 != 3'd5))
          illegal = 1'b1;
      end
      in_opcode == OP_LOAD: begin
        word = {in_imm[11:0], in_rs1,
                in_fun3, in_rd, op7};
        illegal = !fits12 || (in_fun3 == 3'd3)
               || (in_fun3 == 3'd6)
               || (in_fun3 == 3'd7);
      end
      in_opcode == OP_JALR: begin
        word = {in_imm[11:0], in_rs1,
                in_fun3, in_rd, op7};
        illegal = !fits12 || (in_fun3 != 3'd0);
      end
      in_opcode == OP_S: begin
        word = {in_imm[11:5], in_rs2, in_rs1,
                in_fun3, in_imm[4:0], op7};
        illegal = !fits12 || (in_fun3 > 3'd2);
      end
      in_opcode == OP_SB: begin
        word = {in_imm[12], in_imm[10:5], in_rs2,
                in_rs1, in_fun3, in_imm[4:1],
                in_imm[11], op7};
        illegal = !fits13 || in_imm[0]
               || (in_fun3 == 3'd2)
               || (in_fun3 == 3'd3);
      end
      in_opcode == OP_UJ: begin
        word = {in_imm[20], in_imm[10:1], in_imm[11],
                in_imm[19:12], in_rd, op7};
        illegal = !fits21 || in_imm[0];
      end
      (in_opcode == OP_LUI) ||
      (in_opcode == OP_AUIPC): begin
        word = {in_imm[31:12], in_rd, op7};
        illegal = |in_imm[11:0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    err_d  = accept && illegal;
    ecnt_d = ecnt_q;
    if (push) begin
      mem_d[wr_q] = word;
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop)
      rd_d = rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (err_d && (ecnt_q != '1))
      ecnt_d = ecnt_q + ECNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: packing, FIFO flow control,
// illegal-request reporting and synchronous reset.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  opcode_t     in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_fun3;
  logic        in_fun7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        err_illegal;
  logic [15:0] err_count;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  inst_encoder #(.DEPTH(2), .ECNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_fun3(in_fun3), .in_fun7(in_fun7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst),
    .err_illegal(err_illegal), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic req(input opcode_t op,
                     input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic [2:0] f3,
                     input logic f7,
                     input logic [31:0] imm);
    @(negedge clk);
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_fun3   = f3;
    in_fun7   = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic good(input string tag,
                      input opcode_t op,
                      input logic [4:0] rd,
                      input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input logic [2:0] f3,
                      input logic f7,
                      input logic [31:0] imm,
                      input logic [31:0] exp);
    req(op, rd, rs1, rs2, f3, f7, imm);
    chk(tag, out_inst, exp);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, err_illegal}, 32'd0);
    idle();
    chk({tag, "_pop"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic bad(input string tag,
                     input opcode_t op,
                     input logic [2:0] f3,
                     input logic f7,
                     input logic [31:0] imm,
                     input logic [15:0] cnt);
    req(op, 5'd1, 5'd1, 5'd2, f3, f7, imm);
    chk({tag, "_pulse"}, {31'd0, err_illegal}, 32'd1);
    chk({tag, "_nopush"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, err_count}, {16'd0, cnt});
    idle();
    chk({tag, "_pulse_end"}, {31'd0, err_illegal}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_opcode = OP_R;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_fun3   = '0;
    in_fun7   = 1'b0;
    in_imm    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'h0000_0013);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_ecnt", {16'd0, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    good("add", OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0,
         32'd0, 32'h0020_81B3);
    good("sub", OP_R, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1,
         32'd0, 32'h4073_02B3);
    good("addi", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0,
         32'd5, 32'h0050_0093);
    good("addi_m1", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0,
         32'hFFFF_FFFF, 32'hFFF0_0093);
    good("srai", OP_IMM, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1,
         32'd4, 32'h4041_D113);
    good("lui", OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0,
         32'h1234_5000, 32'h1234_50B7);
    good("sw", OP_S, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0,
         32'd4, 32'h0020_A223);
    good("beq", OP_SB, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0,
         32'd8, 32'h0020_8463);
    good("jal_m4", OP_UJ, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0,
         32'hFFFF_FFFC, 32'hFFDF_F0EF);

    out_ready = 1'b0;
    req(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    chk("full_rdy1", {31'd0, in_ready}, 32'd1);
    req(OP_R, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 32'd0);
    chk("full_rdy2", {31'd0, in_ready}, 32'd0);
    chk("full_head", out_inst, 32'h0020_81B3);
    req(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    chk("full_blk", {31'd0, in_ready}, 32'd0);
    chk("full_head2", out_inst, 32'h0020_81B3);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pop1_rdy", {31'd0, in_ready}, 32'd1);
    chk("pop1_inst", out_inst, 32'h4073_02B3);
    @(posedge clk);
    #1;
    chk("pop2_inst", out_inst, 32'h0050_0093);
    chk("pop2_valid", {31'd0, out_valid}, 32'd1);
    idle();
    chk("drain", {31'd0, out_valid}, 32'd0);

    bad("sb_odd", OP_SB, 3'd0, 1'b0, 32'd7, 16'd1);
    bad("ld_f3", OP_LOAD, 3'd3, 1'b0, 32'd0, 16'd2);
    bad("slli32", OP_IMM, 3'd1, 1'b0, 32'd32, 16'd3);
    bad("uj_rng", OP_UJ, 3'd0, 1'b0, 32'h0010_0000,
        16'd4);
    bad("bad_op", opcode_t'(5'b11111), 3'd0, 1'b0,
        32'd0, 16'd5);

    for (int i = 0; i < 10; i++) begin
      req(OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0,
          32'(i));
      chk($sformatf("stream%0d", i), out_inst,
          (32'(i) << 20) | (32'(i + 1) << 7)
          | 32'h13);
      chk($sformatf("stream_rdy%0d", i),
          {31'd0, in_ready}, 32'd1);
    end
    idle();
    chk("stream_end", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    req(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    req(OP_R, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 32'd0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_inst", out_inst, 32'h0000_0013);
    chk("mrst_ecnt", {16'd0, err_count}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
